// File: rtl/eth_reply_framer.sv
// eth_reply_framer: sends one RMII Ethernet frame per read response (preamble, MACs, EtherType, data, pad, FCS).
// Optional ETH_REPLY_QUEUE_EN adds a 4-entry reply queue; without it, reads arriving while busy are dropped.
module eth_reply_framer #(
    parameter logic [47:0] FPGA_MAC  = 48'h69_69_5A_06_54_91,
    parameter logic [47:0] HOST_MAC  = 48'h00_E0_4C_68_1E_0C,
    parameter logic [15:0] ETHERTYPE = 16'h88_B5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] rdata_i,
    input  logic        rw_i,
    input  logic        valid_i,
    output logic        txen,
    output logic [1:0]  txd,
    output logic        busy_o,
    output logic        drop_o
);

    localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;
    localparam logic [7:0]  PRE_LAST  = 8'd31;
    localparam logic [7:0]  BODY_LAST = 8'd239;
    localparam logic [7:0]  FCS_LAST  = 8'd15;
    localparam logic [7:0]  IFG_LAST  = 8'd47;

    typedef enum logic [2:0] {IDLE, PREAMBLE, BODY, FCS, IFG} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        rd_req;
    logic        ifg_done;
    logic        more;
    logic        drop_set;
    logic [15:0] cur_data;
    logic [31:0] crc;
    logic [31:0] fcs_val;
    logic [7:0]  pre_byte;
    logic [7:0]  body_byte;
    logic [1:0]  pre_dibit;
    logic [1:0]  body_dibit;
    logic [1:0]  fcs_dibit;

    assign rd_req   = valid_i & ~rw_i;
    assign ifg_done = (state == IFG) && (cnt == IFG_LAST);
    assign busy_o   = (state != IDLE);

`ifdef ETH_REPLY_QUEUE_EN
    // The head entry is the frame in flight and is released at the end of its gap,
    // so the four entries cover the active reply plus three waiting ones.
    logic [15:0] q_mem [4];
    logic [1:0]  q_wr;
    logic [1:0]  q_rd;
    logic [2:0]  q_cnt;
    logic        q_push;
    logic        q_pop;

    assign q_pop    = ifg_done;
    assign q_push   = rd_req && ((q_cnt != 3'd4) || q_pop);
    assign more     = (q_cnt > 3'd1) || q_push;
    assign drop_set = rd_req && !q_push;
    assign cur_data = q_mem[q_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            q_wr  <= '0;
            q_rd  <= '0;
            q_cnt <= '0;
        end else begin
            if (q_push) begin
                q_mem[q_wr] <= rdata_i;
                q_wr        <= q_wr + 2'd1;
            end
            if (q_pop) begin
                q_rd <= q_rd + 2'd1;
            end
            q_cnt <= q_cnt + {2'b00, q_push} - {2'b00, q_pop};
        end
    end
`else
    logic [15:0] data_q;

    assign more     = 1'b0;
    assign drop_set = rd_req && busy_o;
    assign cur_data = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (rd_req && (state == IDLE)) begin
            data_q <= rdata_i;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 8'd1;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (rd_req) state_nxt = PREAMBLE;
            end
            PREAMBLE: begin
                if (cnt == PRE_LAST) begin
                    state_nxt = BODY;
                    cnt_nxt   = '0;
                end
            end
            BODY: begin
                if (cnt == BODY_LAST) begin
                    state_nxt = FCS;
                    cnt_nxt   = '0;
                end
            end
            FCS: begin
                if (cnt == FCS_LAST) begin
                    state_nxt = IFG;
                    cnt_nxt   = '0;
                end
            end
            IFG: begin
                if (ifg_done) begin
                    state_nxt = more ? PREAMBLE : IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign pre_byte = (cnt[7:2] == 6'd7) ? 8'hD5 : 8'h55;

    always_comb begin
        body_byte = '0;
        case (cnt[7:2])
            6'd0:    body_byte = HOST_MAC[47:40];
            6'd1:    body_byte = HOST_MAC[39:32];
            6'd2:    body_byte = HOST_MAC[31:24];
            6'd3:    body_byte = HOST_MAC[23:16];
            6'd4:    body_byte = HOST_MAC[15:8];
            6'd5:    body_byte = HOST_MAC[7:0];
            6'd6:    body_byte = FPGA_MAC[47:40];
            6'd7:    body_byte = FPGA_MAC[39:32];
            6'd8:    body_byte = FPGA_MAC[31:24];
            6'd9:    body_byte = FPGA_MAC[23:16];
            6'd10:   body_byte = FPGA_MAC[15:8];
            6'd11:   body_byte = FPGA_MAC[7:0];
            6'd12:   body_byte = ETHERTYPE[15:8];
            6'd13:   body_byte = ETHERTYPE[7:0];
            6'd14:   body_byte = cur_data[15:8];
            6'd15:   body_byte = cur_data[7:0];
            default: body_byte = '0;
        endcase
    end

    // Low dibit of each byte goes first; the FCS streams out of ~crc low bits first,
    // which yields least-significant byte first.
    assign pre_dibit  = pre_byte[{cnt[1:0], 1'b0} +: 2];
    assign body_dibit = body_byte[{cnt[1:0], 1'b0} +: 2];
    assign fcs_val    = ~crc;
    assign fcs_dibit  = fcs_val[{cnt[3:0], 1'b0} +: 2];

    always_comb begin
        txen = 1'b0;
        txd  = 2'b00;
        case (state)
            PREAMBLE: begin
                txen = 1'b1;
                txd  = pre_dibit;
            end
            BODY: begin
                txen = 1'b1;
                txd  = body_dibit;
            end
            FCS: begin
                txen = 1'b1;
                txd  = fcs_dibit;
            end
            default: begin
                txen = 1'b0;
                txd  = 2'b00;
            end
        endcase
    end

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int unsigned i = 0; i < 2; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            crc    <= '1;
            drop_o <= 1'b0;
        end else begin
            if (state == BODY) begin
                crc <= crc_step(crc, body_dibit);
            end else if (state != FCS) begin
                crc <= '1;
            end
            if (drop_set) begin
                drop_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_eth_reply_framer.sv
// Directed bench for eth_reply_framer: decodes each frame from txd and compares against
// hand-built headers and a bitwise software CRC-32.
module tb_eth_reply_framer;

    logic        clk;
    logic        rst;
    logic [15:0] rdata_i;
    logic        rw_i;
    logic        valid_i;
    logic        txen;
    logic [1:0]  txd;
    logic        busy_o;
    logic        drop_o;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    eth_reply_framer dut (
        .clk     (clk),
        .rst     (rst),
        .rdata_i (rdata_i),
        .rw_i    (rw_i),
        .valid_i (valid_i),
        .txen    (txen),
        .txd     (txd),
        .busy_o  (busy_o),
        .drop_o  (drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge; holds the strobe for exactly one cycle.
    task automatic strobe(input logic [15:0] d, input logic rw);
        valid_i = 1'b1;
        rw_i    = rw;
        rdata_i = d;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        rw_i    = 1'b0;
        rdata_i = ~d;
    endtask

    task automatic wait_txen(input int unsigned max, input string tag);
        int unsigned n = 0;
        @(negedge clk);
        while (txen !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start"}, {31'd0, txen === 1'b1}, 32'd1);
    endtask

    // Entered at the negedge of the first preamble cycle; leaves at the negedge
    // 336 cycles later (first cycle after the gap).
    task automatic rx_frame(input logic [15:0] d, input string tag);
        logic [1:0]  dib [288];
        logic [7:0]  exp [72];
        logic [7:0]  hdr [14] = '{8'h00, 8'hE0, 8'h4C, 8'h68, 8'h1E, 8'h0C,
                                  8'h69, 8'h69, 8'h5A, 8'h06, 8'h54, 8'h91,
                                  8'h88, 8'hB5};
        logic [31:0] c;
        logic [7:0]  got;
        int unsigned hi  = 0;
        int unsigned bad = 0;

        for (int i = 0; i < 288; i++) begin
            if (i > 0) @(negedge clk);
            if (txen === 1'b1) hi++;
            dib[i] = txd;
        end
        check({tag, "_txen_len"}, hi, 32'd288);

        for (int i = 0; i < 7; i++) exp[i] = 8'h55;
        exp[7] = 8'hD5;
        for (int i = 0; i < 14; i++) exp[8 + i] = hdr[i];
        exp[22] = d[15:8];
        exp[23] = d[7:0];
        for (int i = 24; i < 68; i++) exp[i] = 8'h00;
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < 68; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (c[0] ^ exp[i][j]) c = (c >> 1) ^ 32'hEDB8_8320;
                else                  c = c >> 1;
            end
        end
        c = ~c;
        for (int k = 0; k < 4; k++) exp[68 + k] = c[8*k +: 8];

        for (int i = 0; i < 72; i++) begin
            got = {dib[4*i+3], dib[4*i+2], dib[4*i+1], dib[4*i]};
            check($sformatf("%s_byte%0d", tag, i), {24'd0, got}, {24'd0, exp[i]});
        end

        repeat (48) begin
            @(negedge clk);
            if (txen !== 1'b0 || txd !== 2'b00 || busy_o !== 1'b1) bad++;
        end
        check({tag, "_ifg"}, bad, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int unsigned seen;

        rst     = 1'b1;
        valid_i = 1'b0;
        rw_i    = 1'b0;
        rdata_i = 16'h0000;

        @(negedge clk);
        check("rst_txen", {31'd0, txen}, 32'd0);
        check("rst_txd", {30'd0, txd}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_drop", {31'd0, drop_o}, 32'd0);

        // Read strobe coinciding with reset is discarded silently.
        @(posedge clk); #1;
        valid_i = 1'b1; rdata_i = 16'h7777;
        @(posedge clk); #1;
        valid_i = 1'b0; rst = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (txen !== 1'b0 || busy_o !== 1'b0 || drop_o !== 1'b0) seen++;
        end
        check("rst_strobe_ignored", seen, 32'd0);

        // Write strobe produces nothing.
        @(posedge clk); #1;
        strobe(16'h1234, 1'b1);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (txen !== 1'b0 || busy_o !== 1'b0) seen++;
        end
        check("write_idle", seen, 32'd0);

        // Single read; rdata_i changes right after acceptance.
        @(posedge clk); #1;
        strobe(16'hBEEF, 1'b0);
        @(negedge clk);
        check("beef_latency", {31'd0, txen}, 32'd1);
        rx_frame(16'hBEEF, "beef");
        check("beef_busy_fall", {31'd0, busy_o}, 32'd0);
        check("beef_txen_after", {31'd0, txen}, 32'd0);
        check("beef_drop", {31'd0, drop_o}, 32'd0);

`ifdef ETH_REPLY_QUEUE_EN
        @(posedge clk); #1;
        fork
            begin
                for (int i = 1; i <= 6; i++) strobe(16'(i), 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                check("q_drop_before", {31'd0, drop_o}, 32'd0);
                @(negedge clk);
                check("q_drop_after", {31'd0, drop_o}, 32'd1);
            end
            begin
                wait_txen(4, "q1");
                rx_frame(16'h0001, "q1");
                check("q2_back_to_back", {31'd0, txen}, 32'd1);
                rx_frame(16'h0002, "q2");
                check("q3_back_to_back", {31'd0, txen}, 32'd1);
                rx_frame(16'h0003, "q3");
                check("q4_back_to_back", {31'd0, txen}, 32'd1);
                rx_frame(16'h0004, "q4");
                check("q_busy_fall", {31'd0, busy_o}, 32'd0);
                check("q_txen_after", {31'd0, txen}, 32'd0);
            end
        join
        check("q_drop_sticky", {31'd0, drop_o}, 32'd1);
`else
        @(posedge clk); #1;
        strobe(16'hAAAA, 1'b0);
        fork
            begin
                wait_txen(2, "aaaa");
                rx_frame(16'hAAAA, "aaaa");
                check("aaaa_busy_fall", {31'd0, busy_o}, 32'd0);
                check("aaaa_no_second", {31'd0, txen}, 32'd0);
            end
            begin
                repeat (8) @(posedge clk);
                @(negedge clk);
                check("nq_drop_before", {31'd0, drop_o}, 32'd0);
                @(posedge clk); #1;
                strobe(16'h5555, 1'b0);
                @(negedge clk);
                check("nq_drop_after", {31'd0, drop_o}, 32'd1);
            end
        join
        check("nq_drop_sticky", {31'd0, drop_o}, 32'd1);
`endif

        // Reset at dibit 100 abandons the frame; a later read is complete.
        @(posedge clk); #1;
        strobe(16'h1111, 1'b0);
        wait_txen(2, "abort");
        repeat (100) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_txen", {31'd0, txen}, 32'd0);
        check("abort_txd", {30'd0, txd}, 32'd0);
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        check("abort_drop", {31'd0, drop_o}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        strobe(16'hC0DE, 1'b0);
        @(negedge clk);
        check("c0de_latency", {31'd0, txen}, 32'd1);
        rx_frame(16'hC0DE, "c0de");
        check("c0de_busy_fall", {31'd0, busy_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
